// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types and instruction field layout for the dual-issue scheduler
package sched_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } sched_state_t;

    localparam int FIELD_W = 8;
    localparam int OPC_LO  = 24;
    localparam int SRC1_LO = 16;
    localparam int SRC2_LO = 8;
    localparam int DST_LO  = 0;

    localparam logic [7:0] STORE_OPC = 8'h81;

    // Micro-op bits that claim the memory/bus port exclusively
    localparam int EXCL_HI = 11;
    localparam int EXCL_LO = 5;

    function automatic logic [FIELD_W-1:0] field(input logic [31:0] instr, input int lo);
        return instr[lo +: FIELD_W];
    endfunction

endpackage

// File: rtl/spec_dual_issue_scheduler_if.sv
// rtl/spec_dual_issue_scheduler_if.sv - fetch, control-store and issue signals of the scheduler
interface spec_dual_issue_scheduler_if #(
    parameter int UCODE_W = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 3
);
    logic               fetch_valid;
    logic [INSTR_W-1:0] fetch_instr;
    logic               fetch_ready;
    logic               flush;
    logic               stall;
    logic [INSTR_W-1:0] n_instr;
    logic [CNT_W-1:0]   micro_cnt;
    logic [INSTR_W-1:0] s_instr;
    logic [UCODE_W-1:0] ucode_normal;
    logic               ucode_normal_last;
    logic [UCODE_W-1:0] ucode_spec;
    logic               ucode_spec_single;
    logic               issue_n_valid;
    logic               issue_s_valid;

    modport master (
        input  fetch_valid, fetch_instr, flush, stall,
               ucode_normal, ucode_normal_last, ucode_spec, ucode_spec_single,
        output fetch_ready, n_instr, micro_cnt, s_instr, issue_n_valid, issue_s_valid
    );

    modport slave (
        output fetch_valid, fetch_instr, flush, stall,
               ucode_normal, ucode_normal_last, ucode_spec, ucode_spec_single,
        input  fetch_ready, n_instr, micro_cnt, s_instr, issue_n_valid, issue_s_valid
    );
endinterface

// File: rtl/spec_coissue_judge.sv
// rtl/spec_coissue_judge.sv - resource/dependency judge deciding whether S may pair with N
module spec_coissue_judge
    import sched_pkg::*;
#(
    parameter int UCODE_W = 32
) (
    input  logic [UCODE_W-1:0] ucode_normal,
    input  logic [UCODE_W-1:0] ucode_spec,
    input  logic               ucode_spec_single,
    input  logic [FIELD_W-1:0] n_opc,
    input  logic [FIELD_W-1:0] n_dst,
    input  logic [FIELD_W-1:0] s_src1,
    input  logic [FIELD_W-1:0] s_src2,
    output logic               coissue_ok
);
    logic conflict;
    logic dependent;

    assign conflict  = (|(ucode_normal & ucode_spec)) | (|ucode_normal[EXCL_HI:EXCL_LO]);
    // A store writes no register, so S can never read its result
    assign dependent = (n_opc != STORE_OPC) && ((s_src1 == n_dst) || (s_src2 == n_dst));

    assign coissue_ok = ucode_spec_single & ~conflict & ~dependent;
endmodule

// File: rtl/spec_dual_issue_scheduler.sv
// rtl/spec_dual_issue_scheduler.sv - in-order dual-issue slot controller; SCHED_PERF_CNT_EN adds perf counters
module spec_dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int UCODE_W  = 32,
    parameter int INSTR_W  = 32,
    parameter int CNT_W    = 3,
    parameter int MAX_UOPS = 8
) (
    input  logic clk,
    input  logic rst,
    spec_dual_issue_scheduler_if.master bus
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [15:0] perf_dual_cnt,
    output logic [15:0] perf_block_cnt
`endif
);
    sched_state_t       state;
    logic [INSTR_W-1:0] n_q;
    logic [INSTR_W-1:0] s_q;
    logic [CNT_W-1:0]   cnt_q;

    logic active;
    logic coissue_ok;
    logic retire;
    logic coissue;
    logic fetch_take;

    spec_coissue_judge #(.UCODE_W(UCODE_W)) u_judge (
        .ucode_normal      (bus.ucode_normal),
        .ucode_spec        (bus.ucode_spec),
        .ucode_spec_single (bus.ucode_spec_single),
        .n_opc             (field(n_q[31:0], OPC_LO)),
        .n_dst             (field(n_q[31:0], DST_LO)),
        .s_src1            (field(s_q[31:0], SRC1_LO)),
        .s_src2            (field(s_q[31:0], SRC2_LO)),
        .coissue_ok        (coissue_ok)
    );

    assign active     = ~rst & ~bus.flush & ~bus.stall;
    assign retire     = (state != EMPTY) &
                        (bus.ucode_normal_last | (cnt_q == CNT_W'(MAX_UOPS - 1)));
    assign coissue    = (state == TWO) & active & coissue_ok;
    assign fetch_take = bus.fetch_valid & bus.fetch_ready;

    assign bus.fetch_ready   = (state != TWO) & active;
    assign bus.issue_n_valid = (state != EMPTY) & active;
    assign bus.issue_s_valid = coissue;
    assign bus.n_instr       = n_q;
    assign bus.s_instr       = s_q;
    assign bus.micro_cnt     = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            state <= EMPTY;
            n_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
        end else if (!bus.stall) begin
            case (state)
                EMPTY: if (fetch_take) begin
                    state <= ONE;
                    n_q   <= bus.fetch_instr;
                    cnt_q <= '0;
                end
                ONE: if (retire) begin
                    cnt_q <= '0;
                    if (fetch_take) n_q <= bus.fetch_instr;
                    else            state <= EMPTY;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (fetch_take) begin
                        state <= TWO;
                        s_q   <= bus.fetch_instr;
                    end
                end
                TWO: if (coissue) begin
                    if (retire) begin
                        state <= EMPTY;
                        cnt_q <= '0;
                    end else begin
                        state <= ONE;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else if (retire) begin
                    // S is promoted into N and starts its own microprogram
                    state <= ONE;
                    n_q   <= s_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dual_cnt  <= '0;
            perf_block_cnt <= '0;
        end else begin
            if (coissue && perf_dual_cnt != 16'hFFFF)
                perf_dual_cnt <= perf_dual_cnt + 16'd1;
            if ((state == TWO) && active && !coissue_ok && perf_block_cnt != 16'hFFFF)
                perf_block_cnt <= perf_block_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_spec_dual_issue_scheduler.sv
// tb/tb_spec_dual_issue_scheduler.sv - vector table, corner sequences and random run against a slot-queue model
module tb_spec_dual_issue_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spec_dual_issue_scheduler_if sif ();
`ifdef SCHED_PERF_CNT_EN
    logic [15:0] perf_dual_cnt;
    logic [15:0] perf_block_cnt;
`endif

    spec_dual_issue_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
`ifdef SCHED_PERF_CNT_EN
        ,
        .perf_dual_cnt  (perf_dual_cnt),
        .perf_block_cnt (perf_block_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] n, s, un, us;
        logic        single, last;
        logic        exp_sv;
        logic        exp_nv, exp_fr;
        logic [31:0] exp_n;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[$];

    // Model: queue of occupied slots (index 0 = N, 1 = S) plus N's micro-op index
    logic [31:0] mq[$];
    int          mcnt;
    int          m_dual, m_block;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sif.fetch_valid       = 1'b0;
        sif.fetch_instr       = '0;
        sif.flush             = 1'b0;
        sif.stall             = 1'b0;
        sif.ucode_normal      = '0;
        sif.ucode_normal_last = 1'b0;
        sif.ucode_spec        = '0;
        sif.ucode_spec_single = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reset, then N enters (cnt 0), then S enters while N steps to cnt 1
    task automatic load_two(input logic [31:0] n, input logic [31:0] s);
        do_reset();
        sif.fetch_valid = 1'b1;
        sif.fetch_instr = n;
        tick();
        sif.fetch_instr = s;
        tick();
        sif.fetch_valid = 1'b0;
        sif.fetch_instr = '0;
    endtask

    function automatic bit pair_ok(input logic [31:0] n, input logic [31:0] s,
                                   input logic [31:0] un, input logic [31:0] us,
                                   input logic single);
        bit clash, dep;
        clash = ((un & us) != 0) || (((un >> 5) & 32'h7F) != 0);
        dep   = (n[31:24] != 8'h81) && ((s[23:16] == n[7:0]) || (s[15:8] == n[7:0]));
        return single && !clash && !dep;
    endfunction

    task automatic check_model();
        bit act_ok, co;
        act_ok = !rst && !sif.flush && !sif.stall;
        co = (mq.size() == 2) && act_ok &&
             pair_ok(mq[0], mq[1], sif.ucode_normal, sif.ucode_spec, sif.ucode_spec_single);
        chk("rnd_fetch_ready", sif.fetch_ready, (mq.size() < 2) && act_ok);
        chk("rnd_issue_n", sif.issue_n_valid, (mq.size() > 0) && act_ok);
        chk("rnd_issue_s", sif.issue_s_valid, co);
        if (mq.size() > 0) begin
            chk("rnd_n_instr", sif.n_instr, mq[0]);
            chk("rnd_micro_cnt", sif.micro_cnt, mcnt);
        end
        if (mq.size() == 2) chk("rnd_s_instr", sif.s_instr, mq[1]);
`ifdef SCHED_PERF_CNT_EN
        chk("rnd_perf_dual", perf_dual_cnt, m_dual);
        chk("rnd_perf_block", perf_block_cnt, m_block);
`endif
    endtask

    task automatic model_step();
        int  sz;
        bit  co, ret;
        if (rst || sif.flush) begin
            mq.delete();
            mcnt = 0;
            if (rst) begin
                m_dual  = 0;
                m_block = 0;
            end
        end else if (!sif.stall) begin
            sz  = mq.size();
            co  = (sz == 2) && pair_ok(mq[0], mq[1], sif.ucode_normal, sif.ucode_spec,
                                       sif.ucode_spec_single);
            ret = (sz > 0) && (sif.ucode_normal_last || mcnt == 7);
            if (co && m_dual < 65535) m_dual++;
            if (sz == 2 && !co && m_block < 65535) m_block++;
            if (co) void'(mq.pop_back());
            if (ret) begin
                void'(mq.pop_front());
                mcnt = 0;
            end else if (sz > 0) begin
                mcnt++;
            end
            if (sz < 2 && sif.fetch_valid) mq.push_back(sif.fetch_instr);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Reset with a fetch pending
        sif.fetch_valid = 1'b1;
        sif.fetch_instr = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_fetch_ready", sif.fetch_ready, 1'b0);
        chk("rst_issue_n", sif.issue_n_valid, 1'b0);
        tick();
        rst = 1'b0;
        sif.fetch_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_issue_n", sif.issue_n_valid, 1'b0);
        chk("post_rst_fetch_ready", sif.fetch_ready, 1'b1);
        chk("post_rst_n_instr", sif.n_instr, 32'h0);
        chk("post_rst_s_instr", sif.s_instr, 32'h0);
        chk("post_rst_cnt", sif.micro_cnt, 32'h0);

        // Vector table: pair state TWO with N at cnt 1, then one decision cycle
        vecs = '{
            '{"co_basic",    32'h0203_0405, 32'h0106_0708, 32'h1,   32'h1000, 1, 0, 1, 1, 1, 32'h0203_0405, 2},
            '{"overlap",     32'h0203_0405, 32'h0106_0708, 32'h10,  32'h10,   1, 0, 0, 1, 0, 32'h0203_0405, 2},
            '{"excl_bit5",   32'h0203_0405, 32'h0106_0708, 32'h20,  32'h1000, 1, 0, 0, 1, 0, 32'h0203_0405, 2},
            '{"excl_bit11",  32'h0203_0405, 32'h0106_0708, 32'h800, 32'h1,    1, 0, 0, 1, 0, 32'h0203_0405, 2},
            '{"bit12_free",  32'h0203_0405, 32'h0106_0708, 32'h1000,32'h2000, 1, 0, 1, 1, 1, 32'h0203_0405, 2},
            '{"dep_src1",    32'h0203_0405, 32'h0105_0708, 32'h1,   32'h1000, 1, 0, 0, 1, 0, 32'h0203_0405, 2},
            '{"dep_src2",    32'h0203_0405, 32'h0106_0508, 32'h1,   32'h1000, 1, 0, 0, 1, 0, 32'h0203_0405, 2},
            '{"store_nodep", 32'h8103_0405, 32'h0105_0708, 32'h1,   32'h1000, 1, 0, 1, 1, 1, 32'h8103_0405, 2},
            '{"not_single",  32'h0203_0405, 32'h0106_0708, 32'h1,   32'h1000, 0, 0, 0, 1, 0, 32'h0203_0405, 2},
            '{"promote",     32'h0203_0405, 32'h0106_0708, 32'h1,   32'h1000, 0, 1, 0, 1, 1, 32'h0106_0708, 0},
            '{"co_last",     32'h0203_0405, 32'h0106_0708, 32'h1,   32'h1000, 1, 1, 1, 0, 1, 32'h0,         0}
        };
        foreach (vecs[i]) begin
            load_two(vecs[i].n, vecs[i].s);
            sif.ucode_normal      = vecs[i].un;
            sif.ucode_spec        = vecs[i].us;
            sif.ucode_spec_single = vecs[i].single;
            sif.ucode_normal_last = vecs[i].last;
            @(negedge clk);
            chk({vecs[i].name, "_issue_s"}, sif.issue_s_valid, vecs[i].exp_sv);
            chk({vecs[i].name, "_issue_n"}, sif.issue_n_valid, 1'b1);
            chk({vecs[i].name, "_fetch_ready_two"}, sif.fetch_ready, 1'b0);
            tick();
            idle();
            @(negedge clk);
            chk({vecs[i].name, "_next_issue_n"}, sif.issue_n_valid, vecs[i].exp_nv);
            chk({vecs[i].name, "_next_fetch_ready"}, sif.fetch_ready, vecs[i].exp_fr);
            if (vecs[i].exp_nv) begin
                chk({vecs[i].name, "_next_n_instr"}, sif.n_instr, vecs[i].exp_n);
                chk({vecs[i].name, "_next_cnt"}, sif.micro_cnt, vecs[i].exp_cnt);
            end
        end

        // Flush in TWO drops both slots and the offered instruction
        load_two(32'h0203_0405, 32'h0106_0708);
        sif.flush       = 1'b1;
        sif.fetch_valid = 1'b1;
        sif.fetch_instr = 32'h1111_2222;
        @(negedge clk);
        chk("flush_issue_n", sif.issue_n_valid, 1'b0);
        chk("flush_fetch_ready", sif.fetch_ready, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("post_flush_issue_n", sif.issue_n_valid, 1'b0);
        chk("post_flush_cnt", sif.micro_cnt, 32'h0);
        chk("post_flush_n_instr", sif.n_instr, 32'h0);
        chk("post_flush_s_instr", sif.s_instr, 32'h0);
        chk("post_flush_fetch_ready", sif.fetch_ready, 1'b1);

        // Forced retire at the last micro-op index without wrapping
        do_reset();
        sif.fetch_valid = 1'b1;
        sif.fetch_instr = 32'h0A0B_0C0D;
        tick();
        idle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("bound_cnt", sif.micro_cnt, k);
            chk("bound_issue_n", sif.issue_n_valid, 1'b1);
            tick();
        end
        @(negedge clk);
        chk("bound_retired", sif.issue_n_valid, 1'b0);
        chk("bound_fetch_ready", sif.fetch_ready, 1'b1);

        // Stall freezes TWO for three cycles even with a pairable S
        load_two(32'h0203_0405, 32'h0106_0708);
        sif.stall             = 1'b1;
        sif.ucode_normal      = 32'h1;
        sif.ucode_spec        = 32'h1000;
        sif.ucode_spec_single = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_issue_n", sif.issue_n_valid, 1'b0);
            chk("stall_issue_s", sif.issue_s_valid, 1'b0);
            chk("stall_fetch_ready", sif.fetch_ready, 1'b0);
            chk("stall_n_instr", sif.n_instr, 32'h0203_0405);
            chk("stall_s_instr", sif.s_instr, 32'h0106_0708);
            chk("stall_cnt", sif.micro_cnt, 32'h1);
`ifdef SCHED_PERF_CNT_EN
            chk("stall_perf_block", perf_block_cnt, 16'd0);
`endif
            tick();
        end
        sif.stall             = 1'b0;
        sif.ucode_spec_single = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            @(negedge clk);
            chk("blocked_cnt", sif.micro_cnt, 1 + k);
`ifdef SCHED_PERF_CNT_EN
            chk("blocked_perf_block", perf_block_cnt, k);
            chk("blocked_perf_dual", perf_dual_cnt, 16'd0);
`endif
        end

        // Randomized run against the slot-queue model
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        model_step();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst                   = ($urandom % 500) == 0;
            sif.flush             = ($urandom % 32) == 0;
            sif.stall             = ($urandom % 8) == 0;
            sif.fetch_valid       = $urandom % 2;
            sif.fetch_instr       = {(($urandom % 4) == 0) ? 8'h81 : 8'($urandom),
                                     8'($urandom % 4), 8'($urandom % 4), 8'($urandom % 4)};
            sif.ucode_normal      = (($urandom % 3) == 0) ? 32'h0 : (32'h1 << ($urandom % 32));
            sif.ucode_spec        = 32'h1 << ($urandom % 32);
            sif.ucode_spec_single = ($urandom % 4) != 0;
            sif.ucode_normal_last = ($urandom % 4) == 0;
            @(negedge clk);
            check_model();
            model_step();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
